// File: rtl/byte_serial_adder.sv
// rtl/byte_serial_adder.sv - byte-serial wide adder/subtractor with valid/ready handshakes
// One 8-bit add per clock, LSB byte first, carry registered between bytes.
module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [7:0]    a_byte, b_byte;
  logic [8:0]    byte_res;

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        a_byte = a_q[8*i +: 8];
        b_byte = b_q[8*i +: 8];
      end
    end
    byte_res = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so b is inverted once at capture.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) sum_d[8*i +: 8] = byte_res[7:0];
        end
        carry_d = byte_res[8];
        if (idx_q == LAST_IDX) begin
          cout_d  = byte_res[8];
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (byte_res[7] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// tb/tb_byte_serial_adder.sv - directed self-checking bench for byte_serial_adder
module tb_byte_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout, ovf;

  int tests = 0;
  int fails = 0;

  byte_serial_adder #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Drives one request from IDLE, scrambles the inputs after accept, waits for out_valid.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic sv, output int lat);
    @(negedge clk);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = ~cv; sub = ~sv;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 00000000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL ripple_latency: got %0d cycles, required 4", lat);
    end
    tests++;
    if (sum !== 32'h00000000 || cout !== 1'b1 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL ripple: sum=%h cout=%b ovf=%b, required 00000000 1 0", sum, cout, ovf);
    end
    release_op();

    do_op(32'h000000FF, 32'h00000000, 1'b1, 1'b0, lat);
    tests++;
    if (lat !== 4 || sum !== 32'h00000100 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL carry_in: lat=%0d sum=%h cout=%b ovf=%b, required 4 00000100 0 0", lat, sum, cout, ovf);
    end
    release_op();

    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
    tests++;
    if (sum !== 32'h80000000 || cout !== 1'b0 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL add_ovf: sum=%h cout=%b ovf=%b, required 80000000 0 1", sum, cout, ovf);
    end
    release_op();
  endtask

  task automatic test_sub();
    int lat;
    do_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, lat);
    tests++;
    if (lat !== 4 || sum !== 32'hFFFFFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL sub_borrow: lat=%0d sum=%h cout=%b ovf=%b, required 4 fffffffe 0 0", lat, sum, cout, ovf);
    end
    release_op();

    do_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, lat);
    tests++;
    if (sum !== 32'h7FFFFFFF || cout !== 1'b1 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b, required 7fffffff 1 1", sum, cout, ovf);
    end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat;
    int lat2;
    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
    tests++;
    if (sum !== 32'h23456789 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL bp_result: sum=%h cout=%b ovf=%b, required 23456789 0 0", sum, cout, ovf);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'hDEAD0000 + i; b = 32'h0000BEEF; sub = i[0];
      @(posedge clk); #1;
      tests++;
      if (sum !== 32'h23456789 || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: sum=%h cout=%b ovf=%b in_ready=%b out_valid=%b, required 23456789 0 0 0 1",
                 i, sum, cout, ovf, in_ready, out_valid);
      end
    end
    @(negedge clk);
    out_ready = 1'b1; a = 32'h00000003; b = 32'h00000004; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_accept: in_ready=%b, required 0", in_ready);
    end
    lat2 = 0;
    while (!out_valid && lat2 < 20) begin
      @(posedge clk); #1;
      lat2++;
    end
    tests++;
    if (lat2 !== 4 || sum !== 32'h00000007 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_result: lat=%0d sum=%h cout=%b ovf=%b, required 4 00000007 0 0", lat2, sum, cout, ovf);
    end
    release_op();
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    @(negedge clk);
    a = 32'h11223344; b = 32'h01010101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || sum !== 32'h0 || in_ready !== 1'b1 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL abort: out_valid=%b sum=%h in_ready=%b cout=%b ovf=%b, required 0 00000000 1 0 0",
               out_valid, sum, in_ready, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL abort_no_pulse: out_valid seen %0d cycles, required 0", seen);
    end
    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 4 || sum !== 32'h23456789 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL abort_fresh: lat=%0d sum=%h cout=%b ovf=%b, required 4 23456789 0 0", lat, sum, cout, ovf);
    end
    release_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(32'h00010000, 32'h0000FFFF, 1'b1, 1'b0, lat);
    tests++;
    if (sum !== 32'h00020000 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: sum=%h cout=%b ovf=%b, required 00020000 0 0", sum, cout, ovf);
    end
    release_op();
    do_op(32'h00000000, 32'h00000000, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 4 || sum !== 32'h00000000 || cout !== 1'b1 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d sum=%h cout=%b ovf=%b, required 4 00000000 1 0", lat, sum, cout, ovf);
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
